// File: rtl/ula_operand_sequencer.sv
// ula_operand_sequencer: loads two operands into an external enabled adder, holds EN while the sum settles,
// then captures the 9-bit sum and presents it with a valid/ready handshake.
module ula_operand_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       EN,
    input  logic [8:0] s,
    output logic [8:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       busy
);
    typedef enum logic [1:0] {LOAD_A, LOAD_B, DRIVE, HOLD} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       xfer;

    assign xfer = din_valid && din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        EN           = 1'b0;
        result_valid = 1'b0;
        // din_ready is gated by rst_n so nothing is offered while reset is held
        din_ready    = rst_n && (state == LOAD_A || state == LOAD_B);
        busy         = state != LOAD_A;
        case (state)
            LOAD_A: state_nxt = xfer ? LOAD_B : LOAD_A;
            LOAD_B: state_nxt = xfer ? DRIVE : LOAD_B;
            DRIVE: begin
                EN        = 1'b1;
                state_nxt = (cnt == 4'd0) ? HOLD : DRIVE;
            end
            HOLD: begin
                result_valid = 1'b1;
                state_nxt    = result_ready ? LOAD_A : HOLD;
            end
            default: state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= 8'd0;
            b      <= 8'd0;
            result <= 9'd0;
            cnt    <= 4'd0;
        end else begin
            if (state == LOAD_A && xfer) a <= din;
            if (state == LOAD_B && xfer) begin
                b   <= din;
                cnt <= 4'(SETTLE_CYCLES - 1);
            end
            if (state == DRIVE) begin
                if (cnt == 4'd0) result <= s;
                else             cnt    <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ula_operand_sequencer.sv
// tb_ula_operand_sequencer: directed checks of the operand sequencer with one-cycle and three-cycle settle times,
// each DUT wired to a behavioural adder that drives junk on the sum bus while EN is low.
module tb_ula_operand_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d1 = 8'd0, a1, b1, d3 = 8'd0, a3, b3;
    logic       v1 = 1'b0, r1 = 1'b0, v3 = 1'b0, r3 = 1'b0;
    logic       rdy1, en1, rv1, busy1, rdy3, en3, rv3, busy3;
    logic [8:0] s1, s3, res1, res3;
    int         checks = 0;
    int         errors = 0;
    int         en_cnt;

    // junk value off-enable exposes any capture outside the EN window
    assign s1 = en1 ? ({1'b0, a1} + {1'b0, b1}) : 9'h155;
    assign s3 = en3 ? ({1'b0, a3} + {1'b0, b3}) : 9'h155;

    ula_operand_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(d1), .din_valid(v1), .din_ready(rdy1),
        .a(a1), .b(b1), .EN(en1), .s(s1), .result(res1), .result_valid(rv1),
        .result_ready(r1), .busy(busy1)
    );

    ula_operand_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .din(d3), .din_valid(v3), .din_ready(rdy3),
        .a(a3), .b(b3), .EN(en3), .s(s3), .result(res3), .result_valid(rv3),
        .result_ready(r3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pa [3] = '{8'h00, 8'h80, 8'h55};
    logic [7:0] pb [3] = '{8'h00, 8'h80, 8'hAA};
    logic [8:0] pr [3] = '{9'h000, 9'h100, 9'h0FF};

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready1", 9'(rdy1), 9'd0);
        check("rst_busy1", 9'(busy1), 9'd0);
        check("rst_en1", 9'(en1), 9'd0);
        check("rst_rv1", 9'(rv1), 9'd0);
        check("rst_res1", res1, 9'd0);
        check("rst_ab1", {1'b0, a1 | b1}, 9'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("idle_ready1", 9'(rdy1), 9'd1);
        check("idle_busy1", 9'(busy1), 9'd0);

        // 0x7F + 0x01 with one settle cycle
        v1 = 1'b1; d1 = 8'h7F;
        tick();
        check("a_load", {1'b0, a1}, 9'h07F);
        check("busy_loadb", 9'(busy1), 9'd1);
        d1 = 8'h01;
        tick();
        v1 = 1'b0;
        check("drive_en", 9'(en1), 9'd1);
        check("drive_b", {1'b0, b1}, 9'h001);
        check("drive_ready", 9'(rdy1), 9'd0);
        check("drive_rv", 9'(rv1), 9'd0);
        tick();
        check("hold_en", 9'(en1), 9'd0);
        check("hold_rv", 9'(rv1), 9'd1);
        check("res_7f01", res1, 9'h080);
        r1 = 1'b1;
        tick();
        r1 = 1'b0;
        check("back_rv", 9'(rv1), 9'd0);
        check("back_ready", 9'(rdy1), 9'd1);

        // 0xFF + 0xFF carries into bit 8; stalled consumer, ignored din
        v1 = 1'b1; d1 = 8'hFF;
        tick();
        tick();
        d1 = 8'h33;
        tick();
        check("res_ffff", res1, 9'h1FE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_res", res1, 9'h1FE);
            check("stall_rv", 9'(rv1), 9'd1);
        end
        check("stall_a", {1'b0, a1}, 9'h0FF);
        check("stall_b", {1'b0, b1}, 9'h0FF);
        v1 = 1'b0; r1 = 1'b1;
        tick();

        // back-to-back pairs with result_ready held high
        for (int k = 0; k < 3; k++) begin
            v1 = 1'b1; d1 = pa[k];
            tick();
            d1 = pb[k];
            tick();
            v1 = 1'b0;
            tick();
            check("b2b_rv", 9'(rv1), 9'd1);
            check("b2b_res", res1, pr[k]);
            tick();
            check("b2b_ready", 9'(rdy1), 9'd1);
        end
        r1 = 1'b0;

        // three settle cycles with idle gap between beats
        v3 = 1'b1; d3 = 8'h10;
        tick();
        v3 = 1'b0; d3 = 8'h99;
        tick();
        tick();
        check("gap_a3", {1'b0, a3}, 9'h010);
        v3 = 1'b1; d3 = 8'h20;
        tick();
        d3 = 8'hEE;
        en_cnt = 0;
        for (int i = 0; i < 10 && !rv3; i++) begin
            if (en3) en_cnt++;
            tick();
        end
        check("n3_en_cycles", 9'(en_cnt), 9'd3);
        check("n3_rv", 9'(rv3), 9'd1);
        check("n3_res", res3, 9'h030);
        check("n3_a", {1'b0, a3}, 9'h010);
        check("n3_b", {1'b0, b3}, 9'h020);
        v3 = 1'b0; r3 = 1'b1;
        tick();
        r3 = 1'b0;
        check("n3_idle", 9'(rdy3), 9'd1);

        // asynchronous reset mid-DRIVE abandons the operation
        v3 = 1'b1; d3 = 8'hAB;
        tick();
        d3 = 8'hCD;
        tick();
        v3 = 1'b0;
        check("pre_rst_en3", 9'(en3), 9'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en3", 9'(en3), 9'd0);
        check("arst_rv3", 9'(rv3), 9'd0);
        check("arst_ab3", {1'b0, a3 | b3}, 9'd0);
        check("arst_ready3", 9'(rdy3), 9'd0);
        check("arst_busy3", 9'(busy3), 9'd0);
        rst_n = 1'b1;
        tick();
        v3 = 1'b1; d3 = 8'h01;
        tick();
        d3 = 8'h02;
        tick();
        v3 = 1'b0;
        tick();
        tick();
        check("post_rst_rv_early", 9'(rv3), 9'd0);
        tick();
        check("post_rst_rv", 9'(rv3), 9'd1);
        check("post_rst_res", res3, 9'h003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_operand_sequencer.md
ULA_OPERAND_SEQUENCER -- requirements
Module: ula_operand_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles EN is held high before sum capture; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port din  input  8  operand data; first beat is operand A, second beat is operand B.
REQ-005 SHALL have port din_valid  input  1  din holds a valid operand this cycle.
REQ-006 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-007 SHALL have port a  output  8  operand A register, driven to the 8-bit enabled adder.
REQ-008 SHALL have port b  output  8  operand B register, driven to the 8-bit enabled adder.
REQ-009 SHALL have port EN  output  1  enable for the adder's tri-state sum output.
REQ-010 SHALL have port s  input  9  adder sum bus; s[8] is carry-out; valid only while EN=1.
REQ-011 SHALL have port result  output  9  captured sum.
REQ-012 SHALL have port result_valid  output  1  result holds a new sum.
REQ-013 SHALL have port result_ready  input  1  consumer accepts result this cycle.
REQ-014 SHALL have port busy  output  1  high in every state except LOAD_A.

Function
REQ-015 SHALL implement FSM states LOAD_A, LOAD_B, DRIVE, HOLD.
REQ-016 SHALL assert din_ready only in LOAD_A and LOAD_B; a beat transfers on an edge with din_valid=1 and din_ready=1.
REQ-017 LOAD_A: on transfer, a <= din, go to LOAD_B; otherwise remain; a unchanged.
REQ-018 LOAD_B: on transfer, b <= din, load settle counter with SETTLE_CYCLES-1, go to DRIVE; otherwise remain.
REQ-019 DRIVE: EN SHALL be 1 for exactly SETTLE_CYCLES cycles; counter decrements each edge; on the edge where counter=0, result <= s, go to HOLD.
REQ-020 EN SHALL be 0 in every state other than DRIVE, so the sum bus is released (high-Z) outside DRIVE.
REQ-021 a and b SHALL remain stable from LOAD_B transfer until next LOAD_A transfer.
REQ-022 HOLD: result_valid=1, result stable; on edge with result_ready=1, go to LOAD_A; otherwise remain indefinitely.
REQ-023 result_valid SHALL be 0 in all states other than HOLD.
REQ-024 Latency: with SETTLE_CYCLES=N, result_valid rises N edges after the edge accepting operand B.
REQ-025 din_valid in DRIVE or HOLD SHALL be ignored (din_ready=0); no data lost or overwritten.
REQ-026 result_ready outside HOLD SHALL have no effect.
REQ-027 result SHALL be the unmodified 9-bit s; no truncation, no sign interpretation; carry in result[8].
REQ-028 Back-to-back: HOLD->LOAD_A transition SHALL allow a new A transfer on the very next edge (din_ready=1 in the cycle after result handshake).

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force state LOAD_A, a=0, b=0, EN=0, result=0, result_valid=0, settle counter=0.
REQ-030 Outputs during reset: din_ready=1 is permitted only after rst_n deasserts; while rst_n=0, din_ready SHALL be 0 and busy SHALL be 0.
REQ-031 Reset asserted mid-operation (any state) SHALL abandon the operation; no partial result is ever presented.
REQ-032 First transfer after reset SHALL be treated as operand A.

Verification
REQ-033 N=1: din 0x7F then 0x01 on consecutive cycles -> EN high 1 cycle, result=0x080, result_valid 1 edge after B accepted.
REQ-034 N=1: din 0xFF then 0xFF -> result=0x1FE (result[8]=1); result_ready held 0 for 5 cycles -> result, result_valid unchanged throughout.
REQ-035 N=3: A=0x10, B=0x20 with 2 idle din_valid=0 cycles between beats -> EN high exactly 3 cycles, result=0x030; din_valid pulses during DRIVE ignored.
REQ-036 rst_n pulsed low during DRIVE -> EN, result_valid, a, b drop to 0 asynchronously; next beats 0x01, 0x02 -> result=0x003.
REQ-037 Back-to-back streams: result_ready=1 constantly, pairs (0x00,0x00),(0x80,0x80),(0x55,0xAA) -> results 0x000, 0x100, 0x0FF in order, none dropped or duplicated.
